// File: rtl/stc0_pkg.sv
// Shared types and helpers for the stc0 ingress/egress arbitration logic.
package stc0_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   localparam int HDR_W   = 8;
   localparam int MAX_REQ = 4;

   // Round-robin pick over up to MAX_REQ requesters. Unused high valid bits
   // are zero, so wrapping modulo MAX_REQ yields the same order as modulo NREQ.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [1:0]         ptr);
      logic [MAX_REQ-1:0] pick;
      logic [1:0]         idx;
      pick = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (valid[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/stc0_rr_pick.sv
// Combinational round-robin selector: first valid input at or after ptr, as one-hot.
module stc0_rr_pick
   import stc0_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     onehot
);

   assign onehot = N'(rr_pick(MAX_REQ'(valid), 2'(ptr)));

endmodule

// File: rtl/stc0_ingress_arbiter.sv
// Frame-granular round-robin arbiter feeding the stc0_core byte ingress port,
// with a forced idle gap after each frame and a stall timeout that aborts a frame.
module stc0_ingress_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned DW   = 8,
   parameter int unsigned GAP  = 1,
   parameter int unsigned TOUT = 64
) (
   input  logic               Clk,
   input  logic               ARstN,
   input  logic               Enable,
   input  logic [NREQ-1:0]    ReqValid,
   input  logic [NREQ*DW-1:0] ReqData,
   output logic [NREQ-1:0]    ReqReady,
   output logic [DW-1:0]      ID,
   output logic               IValid,
   output logic [NREQ-1:0]    Grant,
   output logic               Busy,
   output logic               Abort,
   output logic [1:0]         DbgState
);
   import stc0_pkg::*;

   localparam int unsigned PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW       = $clog2(TOUT + 1);
   localparam logic [3:0]  GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   arb_state_t        state, state_n;
   logic [NREQ-1:0]   grant_n, pick;
   logic [PTR_W-1:0]  ptr, ptr_n, gidx, ptr_adv;
   logic [HDR_W-1:0]  rem, rem_n;
   logic              expect_hdr, hdr_n;
   logic [SW-1:0]     stall, stall_n;
   logic [3:0]        gap_cnt, gap_n;
   logic [DW-1:0]     sel_data, id_n;
   logic              ivalid_n, abort_n;
   logic              beat, last, frame_end;

   stc0_rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_pick (
      .valid  (ReqValid),
      .ptr    (ptr),
      .onehot (pick)
   );

   // Handshake: a byte moves on a rising edge where ReqValid[i] & ReqReady[i];
   // ReqReady is a pure decode of registered state and never looks at ReqValid.
   assign ReqReady = (state == XFER) ? Grant : '0;
   assign Busy     = (state != IDLE);
   assign DbgState = state;

   always_comb begin
      sel_data = '0;
      gidx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (Grant[i]) begin
            sel_data = sel_data | ReqData[i*DW +: DW];
            gidx     = PTR_W'(i);
         end
      end
   end

   assign ptr_adv = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
   assign beat    = (state == XFER) && (|(ReqValid & Grant));
   assign last    = expect_hdr ? (sel_data[HDR_W-1:0] == '0) : (rem == HDR_W'(1));

   always_comb begin
      state_n   = state;
      grant_n   = Grant;
      ptr_n     = ptr;
      rem_n     = rem;
      hdr_n     = expect_hdr;
      stall_n   = stall;
      gap_n     = gap_cnt;
      id_n      = ID;
      ivalid_n  = 1'b0;
      abort_n   = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (Enable && (|ReqValid)) begin
               grant_n = pick;
               state_n = XFER;
               hdr_n   = 1'b1;
               stall_n = '0;
            end
         end
         XFER: begin
            if (beat) begin
               stall_n  = '0;
               id_n     = sel_data;
               ivalid_n = 1'b1;
               if (expect_hdr) begin
                  rem_n = sel_data[HDR_W-1:0];
                  hdr_n = 1'b0;
               end else if (rem != '0) begin
                  rem_n = rem - HDR_W'(1);
               end
               frame_end = last;
            end else begin
               if (stall != SW'(TOUT))
                  stall_n = stall + SW'(1);
               // A beat always wins over the timeout, so this only fires on idle cycles.
               if (stall_n == SW'(TOUT)) begin
                  abort_n   = 1'b1;
                  frame_end = 1'b1;
               end
            end
         end
         stc0_pkg::GAP: begin
            if (gap_cnt == 4'd0) begin
               state_n = IDLE;
               grant_n = '0;
            end else begin
               gap_n = gap_cnt - 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
      if (frame_end) begin
         ptr_n = ptr_adv;
         if (GAP == 0) begin
            state_n = IDLE;
            grant_n = '0;
         end else begin
            state_n = stc0_pkg::GAP;
            gap_n   = GAP_LOAD;
         end
      end
   end

   always_ff @(posedge Clk or negedge ARstN) begin
      if (!ARstN) begin
         state      <= IDLE;
         Grant      <= '0;
         ptr        <= '0;
         rem        <= '0;
         expect_hdr <= 1'b0;
         stall      <= '0;
         gap_cnt    <= '0;
         ID         <= '0;
         IValid     <= 1'b0;
         Abort      <= 1'b0;
      end else begin
         state      <= state_n;
         Grant      <= grant_n;
         ptr        <= ptr_n;
         rem        <= rem_n;
         expect_hdr <= hdr_n;
         stall      <= stall_n;
         gap_cnt    <= gap_n;
         ID         <= id_n;
         IValid     <= ivalid_n;
         Abort      <= abort_n;
      end
   end

endmodule
